// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: default widths,
// the halt encoding and the loader state encoding.
package imem_loader_pkg;

   localparam int          NBITS_DEF      = 32;
   localparam int          BYTE_BITS_DEF  = 8;
   localparam int          IMEM_DEPTH_DEF = 256;
   localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

endpackage

// File: rtl/byte_assembler.sv
// Shifts received bytes into an NBITS-wide word, first byte ending up in the
// most significant position. word_ready flags the cycle in which the last
// byte of a word is accepted. Needs at least two bytes per word.
module byte_assembler #(
   parameter int NBITS     = 32,
   parameter int BYTE_BITS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 shift_en,
   input  logic [BYTE_BITS-1:0] rx_data,
   output logic [NBITS-1:0]     word,
   output logic                 word_ready
);

   localparam int BPW   = NBITS / BYTE_BITS;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic [CNT_W-1:0] byte_cnt;

   assign word_ready = shift_en && (byte_cnt == CNT_W'(BPW - 1));

   // Shift register and byte counter; clear discards any partial word.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for every register so all flops
      // update together from pre-edge values, independent of block order.
      if (reset || clear) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (shift_en) begin
         word     <= {word[NBITS-BYTE_BITS-1:0], rx_data};
         byte_cnt <= word_ready ? '0 : byte_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction memory: assembles UART bytes into words and
// writes them at consecutive word-aligned byte addresses from 0, finishing on
// the halt word or flagging an error when memory fills first.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int               NBITS      = NBITS_DEF,
   parameter int               BYTE_BITS  = BYTE_BITS_DEF,
   parameter int               IMEM_DEPTH = IMEM_DEPTH_DEF,
   parameter logic [NBITS-1:0] HALT_WORD  = NBITS'(HALT_WORD_DEF),
   localparam int              WC_W       = $clog2(IMEM_DEPTH) + 1
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [BYTE_BITS-1:0] i_rx_data,
   input  logic                 i_rx_valid,
   output logic                 o_mem_wr_en,
   output logic [NBITS-1:0]     o_mem_addr,
   output logic [NBITS-1:0]     o_mem_wr_data,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_error,
   output logic [WC_W-1:0]      o_word_count
);

   localparam int BPW = NBITS / BYTE_BITS;

   loader_state_t    state, state_nxt;
   logic [NBITS-1:0] addr;        // address of the next word to be written
   logic [NBITS-1:0] last_addr;   // address of the most recent write
   logic [WC_W-1:0]  word_count;
   logic [NBITS-1:0] word;
   logic             word_ready;
   logic             load_start;
   logic             shift_en;
   logic             is_halt;
   logic             last_slot;

   assign is_halt   = (word == HALT_WORD);
   assign last_slot = (word_count == WC_W'(IMEM_DEPTH - 1));

   byte_assembler #(
      .NBITS     (NBITS),
      .BYTE_BITS (BYTE_BITS)
   ) u_byte_assembler (
      .clk        (i_clk),
      .reset      (i_reset),
      .clear      (load_start),
      .shift_en   (shift_en),
      .rx_data    (i_rx_data),
      .word       (word),
      .word_ready (word_ready)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // Next-state decode and state-derived outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_nxt   = state;
      load_start  = 1'b0;
      shift_en    = 1'b0;
      o_mem_wr_en = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_error     = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            o_done     = (state == ST_DONE);
            o_error    = (state == ST_ERROR);
            load_start = i_start;
            if (i_start) state_nxt = ST_RECV;
         end
         ST_RECV: begin
            o_busy   = 1'b1;
            shift_en = i_rx_valid;
            if (word_ready) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            o_busy      = 1'b1;
            o_mem_wr_en = 1'b1;
            // A byte arriving now starts the next word; none is dropped.
            shift_en    = i_rx_valid;
            if (is_halt)        state_nxt = ST_DONE;
            else if (last_slot) state_nxt = ST_ERROR;
            else                state_nxt = ST_RECV;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Address and word counters, restarted whenever a new load begins.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         addr       <= '0;
         last_addr  <= '0;
         word_count <= '0;
      end else if (load_start) begin
         addr       <= '0;
         word_count <= '0;
      end else if (state == ST_WRITE) begin
         last_addr  <= addr;
         word_count <= word_count + WC_W'(1);
         if (!is_halt && !last_slot) addr <= addr + NBITS'(BPW);
      end
   end

   assign o_mem_addr    = (state == ST_WRITE) ? addr : last_addr;
   assign o_mem_wr_data = word;
   assign o_word_count  = word_count;

endmodule
